pwm_fade_controller: RTL and testbench



---
 rtl/pwm_fade_controller.sv | 166 ++++++++++++++++
 tb/tb_pwm_fade_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_controller.sv
// PWM register bank with an autonomous duty-cycle fade engine.
// Host writes always take priority over the engine's own duty updates.
module pwm_fade_controller #(
  parameter int unsigned TICK_DIV = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_valid_i,
  input  logic [2:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] en_reg_out_7_0_o,
  output logic [7:0] en_reg_out_15_8_o,
  output logic [7:0] en_reg_pwm_7_0_o,
  output logic [7:0] en_reg_pwm_15_8_o,
  output logic [7:0] pwm_duty_cycle_o,
  output logic       fade_busy_o,
  output logic       fade_done_o
);

  localparam int unsigned PrescW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

  state_e            state_q, state_d;
  logic [7:0]        out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [7:0]        pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
  logic [7:0]        duty_q, duty_d, step_q, step_d, period_q, period_d;
  logic              en_q, en_d, mode_q, mode_d, done_q, done_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [7:0]        per_q, per_d;

  logic       presc_wrap, tick, wr_duty;
  logic [8:0] sum9;
  logic [7:0] duty_up, duty_dn;

  always_comb begin
    state_d  = state_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
    step_d   = step_q;
    period_d = period_q;
    en_d     = en_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    presc_d  = '0;
    per_d    = '0;

    presc_wrap = (presc_q == PrescMax);
    tick       = (state_q != StIdle) && en_q && presc_wrap && (per_q == period_q);
    wr_duty    = wr_valid_i && (wr_addr_i == 3'd4);
    sum9       = {1'b0, duty_q} + {1'b0, step_q};
    duty_up    = sum9[8] ? 8'hFF : sum9[7:0];
    duty_dn    = (duty_q > step_q) ? (duty_q - step_q) : 8'h00;

    // Period compare uses the live register; an overshoot wraps on the next prescale wrap.
    if (state_q != StIdle) begin
      presc_d = presc_wrap ? '0 : presc_q + PrescW'(1);
      per_d   = per_q;
      if (presc_wrap) begin
        per_d = (per_q >= period_q) ? 8'd0 : per_q + 8'd1;
      end
    end

    // A host duty write discards the coincident step and its end-condition check.
    if (tick && !wr_duty) begin
      unique case (state_q)
        StRampUp: begin
          duty_d = duty_up;
          if (duty_up == 8'hFF) begin
            if (!mode_q) begin
              state_d = StIdle;
              en_d    = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StRampDown;
            end
          end
        end
        StRampDown: begin
          duty_d = duty_dn;
          if (duty_dn == 8'h00) state_d = StRampUp;
        end
        default: ;
      endcase
    end

    if (wr_valid_i) begin
      unique case (wr_addr_i)
        3'd0: out_lo_d = wr_data_i;
        3'd1: out_hi_d = wr_data_i;
        3'd2: pwm_lo_d = wr_data_i;
        3'd3: pwm_hi_d = wr_data_i;
        3'd4: duty_d   = wr_data_i;
        3'd5: begin
          if (state_q == StIdle) begin
            en_d   = wr_data_i[0];
            mode_d = wr_data_i[1];
            if (wr_data_i[0]) begin
              state_d = StRampUp;
              presc_d = '0;
              per_d   = '0;
            end
          end else if (wr_data_i[0]) begin
            mode_d = wr_data_i[1];
          end else begin
            // Stop: hold the pre-edge duty and suppress any completion pulse.
            en_d    = 1'b0;
            state_d = StIdle;
            duty_d  = duty_q;
            done_d  = 1'b0;
            presc_d = '0;
            per_d   = '0;
          end
        end
        3'd6: step_d   = wr_data_i;
        3'd7: period_d = wr_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      pwm_lo_q <= 8'h00;
      pwm_hi_q <= 8'h00;
      duty_q   <= 8'h00;
      step_q   <= 8'h00;
      period_q <= 8'h00;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      per_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q   <= duty_d;
      step_q   <= step_d;
      period_q <= period_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      presc_q  <= presc_d;
      per_q    <= per_d;
    end
  end

  assign en_reg_out_7_0_o  = out_lo_q;
  assign en_reg_out_15_8_o = out_hi_q;
  assign en_reg_pwm_7_0_o  = pwm_lo_q;
  assign en_reg_pwm_15_8_o = pwm_hi_q;
  assign pwm_duty_cycle_o  = duty_q;
  assign fade_busy_o       = (state_q != StIdle);
  assign fade_done_o       = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Randomized and directed stimulus for pwm_fade_controller, checked through an
// expected-output queue fed by a behavioural model of the fade rules.
module tb_pwm_fade_controller;
  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] o0, o1, o2, o3, duty;
  logic       busy, done;

  pwm_fade_controller #(.TICK_DIV(TD)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .wr_valid_i        (wr_valid),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .en_reg_out_7_0_o  (o0),
    .en_reg_out_15_8_o (o1),
    .en_reg_pwm_7_0_o  (o2),
    .en_reg_pwm_15_8_o (o3),
    .pwm_duty_cycle_o  (duty),
    .fade_busy_o       (busy),
    .fade_done_o       (done)
  );

  always #5 clk = ~clk;

  typedef logic [41:0] exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: registers as integers, ramp as busy/direction plus elapsed-cycle arithmetic.
  int m_out[4];
  int m_duty, m_step, m_period, m_mode, m_elapsed, m_pcnt;
  bit m_busy, m_up, m_done;

  function automatic bit m_tick();
    return m_busy && ((m_elapsed % TD) == TD - 1) && (m_pcnt == m_period);
  endfunction

  task automatic model_step(input bit r, input bit v, input int a, input int d);
    bit tick, wrap, was_busy;
    int nd, old_duty;
    if (r) begin
      for (int i = 0; i < 4; i++) m_out[i] = 0;
      m_duty = 0; m_step = 0; m_period = 0; m_mode = 0;
      m_elapsed = 0; m_pcnt = 0; m_busy = 0; m_up = 1; m_done = 0;
      return;
    end
    tick     = m_tick();
    wrap     = ((m_elapsed % TD) == TD - 1);
    was_busy = m_busy;
    old_duty = m_duty;
    m_done   = 0;
    if (m_busy) begin
      if (wrap) m_pcnt = (m_pcnt >= m_period) ? 0 : m_pcnt + 1;
      m_elapsed++;
    end
    if (tick && !(v && a == 4)) begin
      if (m_up) begin
        nd = m_duty + m_step;
        if (nd > 255) nd = 255;
        m_duty = nd;
        if (nd == 255) begin
          if (m_mode == 0) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_up = 0;
          end
        end
      end else begin
        nd = m_duty - m_step;
        if (nd < 0) nd = 0;
        m_duty = nd;
        if (nd == 0) m_up = 1;
      end
    end
    if (v) begin
      case (a)
        0, 1, 2, 3: m_out[a] = d;
        4: m_duty = d;
        5: begin
          if (!was_busy) begin
            m_mode = (d >> 1) & 1;
            if ((d & 1) != 0) begin
              m_busy = 1; m_up = 1; m_elapsed = 0; m_pcnt = 0;
            end
          end else if ((d & 1) != 0) begin
            m_mode = (d >> 1) & 1;
          end else begin
            m_busy = 0; m_duty = old_duty; m_done = 0;
          end
        end
        6: m_step = d;
        7: m_period = d;
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit r, input bit v, input int a, input int d);
    @(negedge clk);
    rst      = r;
    wr_valid = v;
    wr_addr  = 3'(a);
    wr_data  = 8'(d);
    model_step(r, v, a, d);
    exp_q.push_back({8'(m_out[0]), 8'(m_out[1]), 8'(m_out[2]), 8'(m_out[3]),
                     8'(m_duty), m_busy, m_done});
  endtask

  task automatic wr(input int a, input int d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: every clock the DUT presents its full output set.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {o0, o1, o2, o3, duty, busy, done};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got out=%h/%h pwm=%h/%h duty=%h busy=%b done=%b, required out=%h/%h pwm=%h/%h duty=%h busy=%b done=%b",
                   $time, act[41:34], act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
                   e[41:34], e[33:26], e[25:18], e[17:10], e[9:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    bit r, v;
    int a, d;
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    // Register writes, then a reset pulse.
    for (int i = 0; i < 5; i++) wr(i, 8'h11 * (i + 1));
    idle(2);
    cycle(1'b1, 1'b0, 0, 0);
    idle(2);
    // One-shot ramp.
    wr(7, 1); wr(6, 8'h40); wr(4, 8'h80); wr(5, 8'h01);
    idle(24);
    // Triangle ramp, then a host duty write on a tick.
    wr(7, 0); wr(6, 8'h60); wr(4, 8'h00); wr(5, 8'h03);
    idle(30);
    for (int i = 0; i < 64 && !m_tick(); i++) idle(1);
    wr(4, 8'h10);
    idle(12);
    // Stop mid-ramp.
    wr(5, 8'h00);
    idle(100);
    // Zero step, then reset mid-ramp.
    wr(6, 0); wr(5, 8'h01);
    idle(20);
    cycle(1'b1, 1'b0, 0, 0);
    idle(3);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 7);
      d = $urandom_range(0, 255);
      if (a == 7 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 3);
      cycle(r, v, a, d);
    end
    idle(1);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
